// File: rtl/dmem_ctrl.sv
// Data-memory controller: streams an image into RAM, hands the RAM to the
// processor, then streams the downsampled result back out to the host.
module dmem_ctrl #(
  parameter int unsigned IMG_SIZE = 65536,
  parameter logic [18:0] OUT_BASE = 19'h10000,
  parameter int unsigned OUT_SIZE = 16384
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        load_go,
  input  logic        host_valid,
  input  logic [7:0]  host_data,
  output logic        host_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  input  logic [1:0]  MEM,
  input  logic [18:0] proc_addr,
  input  logic [7:0]  proc_wdata,
  output logic [7:0]  proc_rdata,
  input  logic        status,
  output logic        processor_start,
  output logic [18:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE
  } state_t;

  localparam logic [18:0] IMG_LAST = 19'(IMG_SIZE - 1);
  localparam logic [18:0] OUT_LAST = 19'(OUT_SIZE - 1);

  state_t      state;
  logic [18:0] cnt;
  logic [7:0]  out_reg;
  logic        status_q;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      out_reg  <= '0;
      status_q <= 1'b0;
    end else begin
      status_q <= status;
      case (state)
        IDLE, DONE: begin
          if (load_go) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (host_valid) begin
            cnt <= cnt + 19'd1;
            if (cnt == IMG_LAST) state <= START;
          end
        end
        START: state <= RUN;
        RUN: begin
          // Only a fresh rising edge ends the run; a level left over from a
          // previous job must drop first.
          if (status && !status_q) begin
            state <= DUMP_RD;
            cnt   <= '0;
          end
        end
        DUMP_RD:   state <= DUMP_WAIT;
        DUMP_WAIT: begin
          out_reg <= ram_rdata;
          state   <= DUMP_OUT;
        end
        DUMP_OUT: begin
          if (out_ready) begin
            if (cnt == OUT_LAST) begin
              state <= DONE;
            end else begin
              cnt   <= cnt + 19'd1;
              state <= DUMP_RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    host_ready      = 1'b0;
    out_valid       = 1'b0;
    processor_start = 1'b0;
    ram_we          = 1'b0;
    ram_addr        = '0;
    ram_wdata       = '0;
    case (state)
      LOAD: begin
        host_ready = 1'b1;
        if (host_valid) begin
          ram_we    = 1'b1;
          ram_addr  = cnt;
          ram_wdata = host_data;
        end
      end
      START: processor_start = 1'b1;
      RUN: begin
        ram_addr  = proc_addr;
        ram_wdata = proc_wdata;
        ram_we    = (MEM == 2'b10);
      end
      DUMP_RD:  ram_addr  = OUT_BASE + cnt;
      DUMP_OUT: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_data   = out_reg;
  assign proc_rdata = ram_rdata;
  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter IMG_SIZE, 65536, number of input image bytes loaded at RAM addresses 0..IMG_SIZE-1.
REQ-002 Parameter OUT_BASE, 19'h10000, first RAM address of the downsampled result.
REQ-003 Parameter OUT_SIZE, 16384, number of result bytes streamed out.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 load_go  in  1  host request to start a load/process/dump cycle.
REQ-007 host_valid  in  1, host_data  in  8, host_ready  out  1  image load stream.
REQ-008 out_valid  out  1, out_data  out  8, out_ready  in  1  result dump stream.
REQ-009 MEM  in  2  processor memory op: 2'b01 read, 2'b10 write, 2'b00 and 2'b11 idle.
REQ-010 proc_addr  in  19, proc_wdata  in  8, proc_rdata  out  8  processor data port.
REQ-011 status  in  1  processor finished flag; processor_start  out  1  processor start pulse.
REQ-012 ram_addr  out  19, ram_wdata  out  8, ram_we  out  1, ram_rdata  in  8  single-port synchronous RAM; read data valid the cycle after the address is presented.
REQ-013 busy  out  1  high in every state except IDLE and DONE; done  out  1  high in DONE only.

Function
REQ-014 States IDLE, LOAD, START, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE; 19-bit counter cnt.
REQ-015 IDLE/DONE: load_go=1 -> LOAD with cnt=0; load_go is ignored in all other states.
REQ-016 LOAD: host_ready=1; on host_valid&host_ready -> ram_we=1, ram_addr=cnt, ram_wdata=host_data, cnt+1.
REQ-017 LOAD: the write with cnt=IMG_SIZE-1 moves to START; host_valid=0 writes nothing, and cnt holds.
REQ-018 host_ready=0 outside LOAD; host_valid is ignored there.
REQ-019 START: processor_start=1 for exactly one cycle, then RUN; processor_start=0 in all other cycles.
REQ-020 RUN: ram_addr=proc_addr, ram_wdata=proc_wdata, ram_we=(MEM==2'b10), all combinational; proc_rdata=ram_rdata always.
REQ-021 MEM is ignored outside RUN; ram_we=0 except in REQ-016/REQ-020 conditions.
REQ-022 RUN exits to DUMP_RD with cnt=0 only on a registered 0->1 edge of status; status already high on RUN entry does not exit until it falls and rises again.
REQ-023 DUMP_RD: ram_addr=OUT_BASE+cnt (19-bit, wraps mod 2^19), ram_we=0 -> DUMP_WAIT.
REQ-024 DUMP_WAIT: out_reg<=ram_rdata -> DUMP_OUT.
REQ-025 DUMP_OUT: out_valid=1, out_data=out_reg, stable while out_ready=0.
REQ-026 On out_ready: if cnt=OUT_SIZE-1 -> DONE, else cnt+1 -> DUMP_RD.
REQ-027 Minimum dump throughput is one byte per 3 cycles.
REQ-028 out_valid=0 outside DUMP_OUT.
REQ-029 ram_addr=0 and ram_wdata=0 when not driven by REQ-016, REQ-020 or REQ-023.

Reset
REQ-030 RST=1 at any time, including mid-LOAD/RUN/DUMP, immediately forces IDLE with cnt=0 and out_reg=0.
REQ-031 Under RST, all outputs are 0: host_ready, out_valid, out_data, ram_we, ram_addr, ram_wdata, processor_start, busy and done.
REQ-032 RAM contents are not cleared by RST; operation resumes only on the next load_go after RST=0.

Verification (IMG_SIZE=4, OUT_BASE=8, OUT_SIZE=2)
REQ-033 Load: load_go, bytes 11,22,33,44 with host_valid gaps -> RAM writes 0..3 = 11,22,33,44 only on handshake cycles; processor_start pulses one cycle after the 4th write.
REQ-034 Run: MEM=2'b10, proc_addr=8, proc_wdata=A5 then MEM=2'b01, proc_addr=8 -> ram_we one cycle; proc_rdata=A5 the next cycle.
REQ-035 Dump with backpressure: RAM[8]=A5, RAM[9]=5A, status 0->1, out_ready low 5 cycles -> out_data=A5 held stable, then 5A -> DONE, done=1.
REQ-036 Stale status: status=1 throughout START and RUN entry -> stays in RUN until status falls and rises again.
REQ-037 Reset mid-LOAD after 2 bytes -> IDLE, all outputs 0; a new load_go restarts at address 0.
REQ-038 Illegal ops: MEM=2'b11 in RUN and host_valid in RUN -> ram_we stays 0; load_go in DONE -> new LOAD.
